// File: rtl/vmac_pkg.sv
// -----------------------------------------------------------------------------
// vmac_pkg
// Shared types and constants for the vector multiply-add issue controller:
//   accum_op_e   - accumulate operation encodings as decoded by the issue stage
//   vmac_state_e - issue controller FSM states
//   SEW_*        - element-width encodings
//   is_vx()      - true for the vector-scalar (.vx) forms of an op
// -----------------------------------------------------------------------------
package vmac_pkg;

  typedef enum logic [2:0] {
    OP_VMACC_VV  = 3'b000,
    OP_VMACC_VX  = 3'b001,
    OP_VNMSAC_VV = 3'b010,
    OP_VNMSAC_VX = 3'b011,
    OP_VMADD_VV  = 3'b100,
    OP_VMADD_VX  = 3'b101,
    OP_VNMSUB_VV = 3'b110,
    OP_VNMSUB_VX = 3'b111
  } accum_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LAUNCH = 2'b01,
    WAIT   = 2'b10,
    RESP   = 2'b11
  } vmac_state_e;

  localparam logic [1:0] SEW_8       = 2'b00;
  localparam logic [1:0] SEW_16      = 2'b01;
  localparam logic [1:0] SEW_32      = 2'b10;
  localparam logic [1:0] SEW_ILLEGAL = 2'b11;

  // Bit 0 of every accumulate encoding marks the vector-scalar form.
  function automatic logic is_vx(input logic [2:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/vector_scalar_broadcast.sv
// -----------------------------------------------------------------------------
// vector_scalar_broadcast
// Replicates the low SEW bits of a scalar across a VLEN-bit vector so that
// .vx instructions can reuse the vector-vector MAC datapath.
// Ports:
//   rs1   in  32    scalar operand
//   sew   in  2     element width (SEW_8 / SEW_16 / SEW_32; illegal gives 0)
//   bcast out VLEN  rs1[SEW-1:0] repeated VLEN/SEW times
// VLEN must be a multiple of 32.
// -----------------------------------------------------------------------------
module vector_scalar_broadcast
  import vmac_pkg::*;
#(
  parameter int VLEN = 64
) (
  input  logic [31:0]     rs1,
  input  logic [1:0]      sew,
  output logic [VLEN-1:0] bcast
);

  // Built byte-by-byte: byte i of the result takes byte (i mod SEW/8) of rs1,
  // which is the same as repeating the low SEW bits.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    bcast = '0;
    for (int i = 0; i < VLEN / 8; i++) begin
      case (sew)
        SEW_8:   bcast[i*8 +: 8] = rs1[7:0];
        SEW_16:  bcast[i*8 +: 8] = rs1[(i % 2)*8 +: 8];
        SEW_32:  bcast[i*8 +: 8] = rs1[(i % 4)*8 +: 8];
        default: bcast[i*8 +: 8] = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/vector_mac_issue_ctrl.sv
// -----------------------------------------------------------------------------
// vector_mac_issue_ctrl
// Initiator-side controller for the vector multiply-add unit. Accepts one
// decoded multiply-accumulate instruction, builds the MAC operands (with scalar
// broadcast for .vx forms), launches the MAC, waits for done with a timeout and
// returns the result to writeback.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   issue_valid / issue_ready       instruction handshake
//   issue_op/sew/signed/vs1/vs2/vd/rs1  decoded instruction fields
//   mac_data_A/B/C                  MAC operands (registered)
//   mac_accum_op, mac_sew, mac_signed_mode, mac_ctrl,
//   mac_sew_16_32, mac_sew_32, mac_count_0   MAC controls (registered)
//   mac_result, mac_done            MAC result and completion
//   wb_valid / wb_ready             writeback handshake
//   wb_data, wb_error               result, error (timeout or illegal SEW)
// -----------------------------------------------------------------------------
`ifndef MAX_VLEN
`define MAX_VLEN 64
`endif

module vector_mac_issue_ctrl
  import vmac_pkg::*;
#(
  parameter int VLEN           = `MAX_VLEN,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [2:0]      issue_op,
  input  logic [1:0]      issue_sew,
  input  logic            issue_signed,
  input  logic [VLEN-1:0] issue_vs1,
  input  logic [VLEN-1:0] issue_vs2,
  input  logic [VLEN-1:0] issue_vd,
  input  logic [31:0]     issue_rs1,
  output logic [VLEN-1:0] mac_data_A,
  output logic [VLEN-1:0] mac_data_B,
  output logic [VLEN-1:0] mac_data_C,
  output logic [2:0]      mac_accum_op,
  output logic [1:0]      mac_sew,
  output logic            mac_signed_mode,
  output logic            mac_ctrl,
  output logic            mac_sew_16_32,
  output logic            mac_sew_32,
  output logic            mac_count_0,
  input  logic [VLEN-1:0] mac_result,
  input  logic            mac_done,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [VLEN-1:0] wb_data,
  output logic            wb_error
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  vmac_state_e     state_q, state_d;
  logic [VLEN-1:0] data_a_q, data_a_d;
  logic [VLEN-1:0] data_b_q, data_b_d;
  logic [VLEN-1:0] data_c_q, data_c_d;
  accum_op_e       op_q, op_d;
  logic [1:0]      sew_q, sew_d;
  logic            signed_q, signed_d;
  logic            ctrl_q, ctrl_d;
  logic            sew_16_32_q, sew_16_32_d;
  logic            sew_32_q, sew_32_d;
  logic            count_0_q, count_0_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [VLEN-1:0] wb_data_q, wb_data_d;
  logic            wb_error_q, wb_error_d;

  logic [VLEN-1:0] rs1_bcast;

  vector_scalar_broadcast #(
    .VLEN (VLEN)
  ) u_bcast (
    .rs1   (issue_rs1),
    .sew   (issue_sew),
    .bcast (rs1_bcast)
  );

  always_comb begin
    state_d     = state_q;
    data_a_d    = data_a_q;
    data_b_d    = data_b_q;
    data_c_d    = data_c_q;
    op_d        = op_q;
    sew_d       = sew_q;
    signed_d    = signed_q;
    ctrl_d      = ctrl_q;
    sew_16_32_d = sew_16_32_q;
    sew_32_d    = sew_32_q;
    count_0_d   = 1'b0;
    cnt_d       = cnt_q;
    wb_data_d   = wb_data_q;
    wb_error_d  = wb_error_q;

    unique case (state_q)
      IDLE: begin
        if (issue_valid) begin
          if (issue_sew == SEW_ILLEGAL) begin
            // Operand registers stay zero: the MAC is never launched.
            state_d    = RESP;
            wb_data_d  = '0;
            wb_error_d = 1'b1;
          end else begin
            state_d     = LAUNCH;
            data_a_d    = is_vx(issue_op) ? rs1_bcast : issue_vs1;
            data_b_d    = issue_vs2;
            data_c_d    = issue_vd;
            op_d        = accum_op_e'(issue_op);
            sew_d       = issue_sew;
            signed_d    = issue_signed;
            ctrl_d      = issue_op[1];
            sew_16_32_d = (issue_sew != SEW_8);
            sew_32_d    = (issue_sew == SEW_32);
            count_0_d   = 1'b1;
            cnt_d       = '0;
          end
        end
      end

      LAUNCH: begin
        // mac_done is deliberately not looked at here.
        state_d = WAIT;
      end

      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Done takes priority over a timeout landing in the same cycle.
        if (mac_done) begin
          state_d    = RESP;
          wb_data_d  = mac_result;
          wb_error_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = RESP;
          wb_data_d  = '0;
          wb_error_d = 1'b1;
        end
      end

      RESP: begin
        if (wb_ready) begin
          // Returning to IDLE clears everything so idle outputs read zero.
          state_d     = IDLE;
          data_a_d    = '0;
          data_b_d    = '0;
          data_c_d    = '0;
          op_d        = OP_VMACC_VV;
          sew_d       = '0;
          signed_d    = 1'b0;
          ctrl_d      = 1'b0;
          sew_16_32_d = 1'b0;
          sew_32_d    = 1'b0;
          cnt_d       = '0;
          wb_data_d   = '0;
          wb_error_d  = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset as well as control, because the
    // outputs they drive must read zero in IDLE straight after reset.
    if (reset) begin
      state_q     <= IDLE;
      data_a_q    <= '0;
      data_b_q    <= '0;
      data_c_q    <= '0;
      op_q        <= OP_VMACC_VV;
      sew_q       <= '0;
      signed_q    <= 1'b0;
      ctrl_q      <= 1'b0;
      sew_16_32_q <= 1'b0;
      sew_32_q    <= 1'b0;
      count_0_q   <= 1'b0;
      cnt_q       <= '0;
      wb_data_q   <= '0;
      wb_error_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      data_c_q    <= data_c_d;
      op_q        <= op_d;
      sew_q       <= sew_d;
      signed_q    <= signed_d;
      ctrl_q      <= ctrl_d;
      sew_16_32_q <= sew_16_32_d;
      sew_32_q    <= sew_32_d;
      count_0_q   <= count_0_d;
      cnt_q       <= cnt_d;
      wb_data_q   <= wb_data_d;
      wb_error_q  <= wb_error_d;
    end
  end

  assign issue_ready     = (state_q == IDLE);
  assign wb_valid        = (state_q == RESP);
  assign wb_data         = wb_data_q;
  assign wb_error        = wb_error_q;
  assign mac_data_A      = data_a_q;
  assign mac_data_B      = data_b_q;
  assign mac_data_C      = data_c_q;
  assign mac_accum_op    = op_q;
  assign mac_sew         = sew_q;
  assign mac_signed_mode = signed_q;
  assign mac_ctrl        = ctrl_q;
  assign mac_sew_16_32   = sew_16_32_q;
  assign mac_sew_32      = sew_32_q;
  assign mac_count_0     = count_0_q;

endmodule

// File: doc/vector_mac_issue_ctrl.md
# vector_mac_issue_ctrl

Initiator-side controller for the vector multiply-add unit. Accepts one decoded vector multiply-accumulate instruction at a time from the issue stage over a valid/ready handshake. It then:
- builds the MAC unit's operand and control inputs, including scalar broadcast for `.vx` forms;
- launches the MAC unit and waits for its done indication, with a timeout;
- returns the result to writeback over a second valid/ready handshake.

It sits between the vector issue/decode logic and the multiply-add datapath.

## Interface
Parameters:
- `VLEN`, default `` `MAX_VLEN ``: vector register width in bits.
- `TIMEOUT_CYCLES`, default 64: WAIT cycles allowed before declaring a MAC timeout.

Ports:
- `clk`  in  1  clock. One clock domain only.
- `reset`  in  1  synchronous, active-high reset.
- `issue_valid` in 1; `issue_ready` out 1: instruction handshake.
- `issue_op`  in  3  accum op: 000 VMACC_VV, 001 VMACC_VX, 010 VNMSAC_VV, 011 VNMSAC_VX, 100 VMADD_VV, 101 VMADD_VX, 110 VNMSUB_VV, 111 VNMSUB_VX.
- `issue_sew`  in  2  element width: 00 = 8, 01 = 16, 10 = 32, 11 = illegal.
- `issue_signed`  in  1  signed multiply.
- `issue_vs1`, `issue_vs2`, `issue_vd`  in  VLEN  source vector operands.
- `issue_rs1`  in  32  scalar operand for `.vx` forms.
- `mac_data_A`, `mac_data_B`, `mac_data_C`  out  VLEN  MAC operands.
- `mac_accum_op` out 3; `mac_sew` out 2; `mac_signed_mode` out 1.
- `mac_ctrl`, `mac_sew_16_32`, `mac_sew_32`, `mac_count_0`  out  1  MAC controls.
- `mac_result`  in  VLEN; `mac_done`  in  1  MAC result and done indication.
- `wb_valid` out 1; `wb_ready` in 1: writeback handshake.
- `wb_data`  out  VLEN  result.
- `wb_error`  out  1  timeout or illegal SEW.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP.
  - IDLE: `issue_ready` = 1.
  - On `issue_valid && issue_ready`, all issue fields are registered.
    - Legal SEW: go to LAUNCH.
    - `issue_sew` = 11: go to RESP with `wb_error` = 1 and `wb_data` = 0. The MAC unit is never launched.
  - LAUNCH: one cycle with `mac_count_0` = 1. Go to WAIT. `mac_done` is ignored in this cycle.
  - WAIT: a timeout counter increments each cycle.
    - First cycle with `mac_done` = 1: register `mac_result` into `wb_data` with `wb_error` = 0, then go to RESP.
    - Counter reaches `TIMEOUT_CYCLES` with `mac_done` low: go to RESP with `wb_error` = 1 and `wb_data` = 0.
    - If both happen in the same cycle, `mac_done` wins.
  - RESP: `wb_valid` = 1, and `wb_data`/`wb_error` are held stable. On `wb_ready`, go to IDLE.
- Operand build. All MAC outputs are driven from registers and held constant from LAUNCH through RESP.
  - `mac_data_A` = `vs1` when `op[0]` = 0. Otherwise it is `rs1[SEW-1:0]` replicated VLEN/SEW times.
  - `mac_data_B` = `vs2`.
  - `mac_data_C` = `vd`.
  - `mac_accum_op` = `op`.
  - `mac_ctrl` = `op[1]`. A value of 1 selects addend minus product (the negated forms).
  - `mac_sew_16_32` = (`sew` != 00).
  - `mac_sew_32` = (`sew` == 10).
- Reset and idle values:
  - Reset: state = IDLE, counter = 0.
  - While IDLE, all outputs are 0 except `issue_ready` = 1.
  - Reset in any state abandons the in-flight instruction with no writeback.

## Timing
- Accept at cycle T:
  - `mac_count_0` is high in T+1 only.
  - WAIT begins at T+2.
- Done sampled at cycle D (D ≥ T+2): `wb_valid` rises at D+1.
- Timeout with no done: `wb_valid` rises at T+2+`TIMEOUT_CYCLES`.
- Illegal SEW: `wb_valid` rises at T+1.
- Writeback: the handshake at cycle W gives IDLE at W+1, where `issue_ready` = 1.
- No overlap. `issue_ready` = 0 from T+1 until W+1.
- Minimum issue-to-issue interval is 4 cycles.

## Structure
- Package `vmac_pkg` holds:
  - `accum_op_e` (8 encodings above);
  - `vmac_state_e` (IDLE/LAUNCH/WAIT/RESP);
  - SEW constants `SEW_8` = 00, `SEW_16` = 01, `SEW_32` = 10.
- Sub-module `vector_scalar_broadcast`: combinational, inputs `rs1[31:0]` and `sew`, output replicated VLEN-bit vector.
- Top level: FSM, operand registers, timeout counter, result register.

## Test plan
All scenarios use `VLEN` = 64.
- VMACC_VX, sew = 00, `rs1` = 0x00000003, `vd` = 0x0101010101010101.
  - Required: `mac_data_A` = 0x0303030303030303, `mac_ctrl` = 0, `mac_count_0` high exactly at T+1.
  - MAC model returns done at T+5 with 0x04: `wb_valid` at T+6, `wb_data` = 0x04, `wb_error` = 0.
- VNMSAC_VV, sew = 10.
  - Required: `mac_ctrl` = 1, `mac_sew_16_32` = 1, `mac_sew_32` = 1, `mac_data_A` = `vs1`, `mac_data_C` = `vd`.
- `mac_done` held low.
  - Required: `wb_valid` at T+66 with `wb_error` = 1 and `wb_data` = 0.
  - Done arriving in the same cycle as the 64th WAIT cycle: result accepted, `wb_error` = 0.
- `wb_ready` held low for 5 cycles in RESP.
  - Required: `wb_data` stable, `issue_ready` = 0, a second `issue_valid` not accepted.
  - Second issue accepted one cycle after the handshake.
- `issue_sew` = 11.
  - Required: `mac_count_0` never asserted; `wb_valid` at T+1 with `wb_error` = 1.
- `reset` asserted in WAIT.
  - Required: next cycle IDLE, all outputs 0, `issue_ready` = 1.
  - No `wb_valid` for the dropped instruction, even if `mac_done` then pulses.
